cordic_iter_engine: RTL and testbench
=====================================

// Module: cordic_iter_engine
// PURPOSE
//  Sequential CORDIC iteration engine. It performs one micro-rotation per clock on x/y/z, for one operand set per start.
//  It sits directly upstream of di_ei_LUT: it drives the LUT's count_in/coordinate_system_in and consumes di_ei_output_out
//  (elementary angle e_i) in the same cycle. Supports circular, linear and hyperbolic systems in rotation or vectoring mode.
// PARAMETERS
//  WHOLE_BIT_WIDTH  2   integer bits (incl. sign) of all fixed-point operands; fraction = BIT_WIDTH-WHOLE_BIT_WIDTH
//  BIT_WIDTH        16  total width of x/y/z and of the LUT e_i word
//  NUM_ITER         14  last iteration index i (1..62); count width fixed at 6
// PORTS
//  clk_in                 in   1          clock, rising edge
//  rst_in                 in   1          synchronous, active-high reset
//  start_in               in   1          request; sampled only in IDLE
//  coordinate_system_in   in   2          01 circular, 00 linear, 11 hyperbolic, 10 illegal
//  mode_in                in   1          0 rotation (drive z->0), 1 vectoring (drive y->0)
//  x_in, y_in, z_in       in   BIT_WIDTH  signed two's-complement operands, latched on accepted start
//  di_ei_in               in   BIT_WIDTH  e_i from the LUT for the current count_out/coordinate_system_out
//  count_out              out  6          iteration index i to the LUT
//  coordinate_system_out  out  2          latched coordinate system to the LUT
//  busy_out               out  1          high from the cycle after an accepted start through the DONE cycle
//  done_out               out  1          one-cycle pulse; results valid
//  error_out              out  1          set with done_out when coordinate system was 10; cleared on next accepted start
//  x_out, y_out, z_out    out  BIT_WIDTH  results, held until the next accepted start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including count_out, busy, done and error.
//  FSM: IDLE -> ITER on start_in (legal system); IDLE -> DONE on start_in with system 10 (no iterations, error_out=1);
//       ITER -> DONE after the final scheduled index; DONE -> IDLE unconditionally (1 cycle).
//  start_in outside IDLE is ignored; operands are not re-latched.
//  Index schedule: circular/linear i=0..NUM_ITER; hyperbolic i=1..NUM_ITER, with i=4 and i=13 each issued twice
//       when <=NUM_ITER. count_out holds the current i during ITER and 0 outside ITER.
//  Iteration (one per ITER cycle; m=+1 circ, 0 lin, -1 hyp):
//   sigma = rotation: (z>=0 ? +1 : -1); vectoring: (y<0 ? +1 : -1)
//   x' = x - m*sigma*(y>>>i);  y' = y + sigma*(x>>>i);  z' = z - sigma*e_i
//   Shifts are arithmetic. i>=BIT_WIDTH yields sign fill. Add/sub are BIT_WIDTH modular (wrap, no saturation).
//   Linear: x is never updated.
//  Latency: start accepted at edge k -> first ITER cycle k+1 -> done_out at cycle k+1+S, where
//   S = number of scheduled indices (circ/lin NUM_ITER+1; hyp NUM_ITER+repeats).
//  x/y/z_out are updated with the final registers in the DONE cycle. They keep their previous values during ITER.
//  Reset mid-operation: abort, return to IDLE, zero all outputs the next cycle; no done_out.
//  Simultaneous rst_in and start_in: reset wins.
//  Gain: no K compensation; the caller prescales.
// STRUCTURE
//  cordic_pkg: coord_sys_t encodings (CIRC/LIN/HYP/ILLEGAL), cordic_mode_t, state_t {IDLE,ITER,DONE},
//   hyperbolic repeat indices (4, 13).
//  Sub-module cordic_iter_ctrl: FSM, index counter, repeat logic, busy/done/error.
//  Parent: datapath registers and shift/add.
//  di_ei_LUT is instantiated by the parent system, not inside this block.
// TESTING (bench instantiates di_ei_LUT alongside; BIT_WIDTH 16, WHOLE 2, so 1.0 = 16384)
//  1 circ vectoring x=16384,y=0,z=0 -> done at k+16; x_out=26981+/-4, y_out=0+/-4, z_out=0+/-4
//  2 circ rotation x=9949,y=0,z=12868 (pi/4) -> x_out=y_out=11585+/-6
//  3 lin rotation x=8192,y=0,z=8192 -> y_out=4096+/-2, x_out=8192 exactly
//  4 hyp start -> count_out 1,2,3,4,4,5..13,13,14; done_out exactly at k+17, single cycle
//  5 coord=10 -> done_out and error_out at k+1, busy 1 cycle, x/y/z_out unchanged
//  6 rst_in at 5th ITER cycle -> all outputs 0 next cycle, no done_out; start during ITER ignored (latency unchanged)

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared encodings and constants for the sequential CORDIC iteration engine.
package cordic_pkg;

    // Coordinate system select (m = +1 circular, 0 linear, -1 hyperbolic)
    typedef enum logic [1:0] {
        COORD_LIN     = 2'b00,
        COORD_CIRC    = 2'b01,
        COORD_ILLEGAL = 2'b10,
        COORD_HYP     = 2'b11
    } coord_sys_t;

    // Rotation drives z toward zero, vectoring drives y toward zero
    typedef enum logic {
        MODE_ROT = 1'b0,
        MODE_VEC = 1'b1
    } cordic_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int COUNT_W = 6;

    // Hyperbolic iterations that must be issued twice for convergence
    localparam logic [COUNT_W-1:0] HYP_REPEAT_A = 6'd4;
    localparam logic [COUNT_W-1:0] HYP_REPEAT_B = 6'd13;

    function automatic logic is_hyp_repeat(input logic [COUNT_W-1:0] idx);
        return (idx == HYP_REPEAT_A) || (idx == HYP_REPEAT_B);
    endfunction

endpackage

// File: rtl/cordic_iter_ctrl.sv
// Control for the CORDIC engine: FSM, iteration index schedule, hyperbolic
// repeat handling and the busy/done/error status flags.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int NUM_ITER = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         coord_sys,
    output logic [COUNT_W-1:0] count,
    output logic [1:0]         coord_lat,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               load,
    output logic               step,
    output logic               last
);

    localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(NUM_ITER);

    state_t state;
    logic   rep_taken;
    logic   repeat_now;

    // Decode the current schedule position for the datapath
    always_comb begin
        repeat_now = (coord_lat == COORD_HYP) && is_hyp_repeat(count) && !rep_taken;
        load       = (state == ST_IDLE) && start && (coord_sys != COORD_ILLEGAL);
        step       = (state == ST_ITER);
        last       = step && !repeat_now && (count == LAST_IDX);
    end

    // FSM with registered index counter and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            coord_lat <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            rep_taken <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        coord_lat <= coord_sys;
                        busy      <= 1'b1;
                        rep_taken <= 1'b0;
                        if (coord_sys == COORD_ILLEGAL) begin
                            // No iterations: report the error with the done pulse
                            state <= ST_DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                            count <= '0;
                        end else begin
                            state <= ST_ITER;
                            error <= 1'b0;
                            // Hyperbolic has no i=0 term (atanh(1) diverges)
                            count <= (coord_sys == COORD_HYP) ? COUNT_W'(1) : '0;
                        end
                    end
                end
                ST_ITER: begin
                    if (repeat_now) begin
                        rep_taken <= 1'b1;
                    end else begin
                        rep_taken <= 1'b0;
                        if (count == LAST_IDX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            count <= '0;
                        end else begin
                            count <= count + COUNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cordic_iter_engine.sv
// Sequential CORDIC engine: one micro-rotation per clock on x/y/z using the
// elementary angle supplied by an external LUT for the current index.
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int WHOLE_BIT_WIDTH = 2,
    parameter int BIT_WIDTH       = 16,
    parameter int NUM_ITER        = 14
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic [1:0]                  coordinate_system_in,
    input  logic                        mode_in,
    input  logic signed [BIT_WIDTH-1:0] x_in,
    input  logic signed [BIT_WIDTH-1:0] y_in,
    input  logic signed [BIT_WIDTH-1:0] z_in,
    input  logic signed [BIT_WIDTH-1:0] di_ei_in,
    output logic [COUNT_W-1:0]          count_out,
    output logic [1:0]                  coordinate_system_out,
    output logic                        busy_out,
    output logic                        done_out,
    output logic                        error_out,
    output logic signed [BIT_WIDTH-1:0] x_out,
    output logic signed [BIT_WIDTH-1:0] y_out,
    output logic signed [BIT_WIDTH-1:0] z_out
);

    // Reject parameter sets the fixed-point format or the 6-bit index cannot hold
    if (WHOLE_BIT_WIDTH < 1 || WHOLE_BIT_WIDTH >= BIT_WIDTH ||
        NUM_ITER < 1 || NUM_ITER > 62) begin : g_param_check
        $error("cordic_iter_engine: unsupported parameter combination");
    end

    logic         load;
    logic         step;
    logic         last;
    cordic_mode_t mode_r;

    logic signed [BIT_WIDTH-1:0] x_r, y_r, z_r;
    logic signed [BIT_WIDTH-1:0] x_sh, y_sh;
    logic signed [BIT_WIDTH-1:0] x_next, y_next, z_next;
    logic                        sigma_pos;

    // Modular add/subtract: results wrap at BIT_WIDTH, no saturation
    function automatic logic signed [BIT_WIDTH-1:0] add_sub(
        input logic signed [BIT_WIDTH-1:0] a,
        input logic signed [BIT_WIDTH-1:0] b,
        input logic                        sub
    );
        return sub ? (a - b) : (a + b);
    endfunction

    cordic_iter_ctrl #(
        .NUM_ITER (NUM_ITER)
    ) u_ctrl (
        .clk       (clk_in),
        .rst       (rst_in),
        .start     (start_in),
        .coord_sys (coordinate_system_in),
        .count     (count_out),
        .coord_lat (coordinate_system_out),
        .busy      (busy_out),
        .done      (done_out),
        .error     (error_out),
        .load      (load),
        .step      (step),
        .last      (last)
    );

    // One micro-rotation: direction from z (rotation) or y (vectoring)
    always_comb begin
        sigma_pos = (mode_r == MODE_ROT) ? ~z_r[BIT_WIDTH-1] : y_r[BIT_WIDTH-1];
        // Shift amounts past the word width leave pure sign fill
        x_sh = x_r >>> count_out;
        y_sh = y_r >>> count_out;
        case (coord_sys_t'(coordinate_system_out))
            COORD_CIRC: x_next = add_sub(x_r, y_sh, sigma_pos);
            COORD_HYP:  x_next = add_sub(x_r, y_sh, ~sigma_pos);
            default:    x_next = x_r;
        endcase
        y_next = add_sub(y_r, x_sh, ~sigma_pos);
        z_next = add_sub(z_r, di_ei_in, sigma_pos);
    end

    // Working registers and result registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            mode_r <= MODE_ROT;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
        end else if (load) begin
            x_r    <= x_in;
            y_r    <= y_in;
            z_r    <= z_in;
            mode_r <= cordic_mode_t'(mode_in);
        end else if (step) begin
            x_r <= x_next;
            y_r <= y_next;
            z_r <= z_next;
            // Results appear together with done and stay until the next run ends
            if (last) begin
                x_out <= x_next;
                y_out <= y_next;
                z_out <= z_next;
            end
        end
    end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Self-checking bench for cordic_iter_engine with a behavioural e_i LUT and
// an integer reference model of the CORDIC iteration.
module tb_cordic_iter_engine;

    localparam int BW   = 16;
    localparam int NITR = 14;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic                 start_in = 1'b0;
    logic [1:0]           coordinate_system_in = 2'b01;
    logic                 mode_in = 1'b0;
    logic signed [BW-1:0] x_in = '0, y_in = '0, z_in = '0;
    logic signed [BW-1:0] di_ei_in;
    logic [5:0]           count_out;
    logic [1:0]           coordinate_system_out;
    logic                 busy_out, done_out, error_out;
    logic signed [BW-1:0] x_out, y_out, z_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int e_tab [4][64];
    int cnt_q [$];

    cordic_iter_engine #(
        .WHOLE_BIT_WIDTH (2),
        .BIT_WIDTH       (BW),
        .NUM_ITER        (NITR)
    ) dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .start_in              (start_in),
        .coordinate_system_in  (coordinate_system_in),
        .mode_in               (mode_in),
        .x_in                  (x_in),
        .y_in                  (y_in),
        .z_in                  (z_in),
        .di_ei_in              (di_ei_in),
        .count_out             (count_out),
        .coordinate_system_out (coordinate_system_out),
        .busy_out              (busy_out),
        .done_out              (done_out),
        .error_out             (error_out),
        .x_out                 (x_out),
        .y_out                 (y_out),
        .z_out                 (z_out)
    );

    always #5 clk_in = ~clk_in;

    // Stand-in for di_ei_LUT: combinational lookup by index and system
    always_comb di_ei_in = BW'(e_tab[coordinate_system_out][count_out]);

    function automatic longint shr(input longint v, input int i);
        longint p;
        if (i >= BW) return (v < 0) ? -1 : 0;
        p = longint'(1) << i;
        if (v >= 0) return v / p;
        return -((-v + p - 1) / p);
    endfunction

    function automatic longint wrap(input longint v);
        longint t;
        t = v % 65536;
        if (t < 0) t += 65536;
        if (t >= 32768) t -= 65536;
        return t;
    endfunction

    function automatic longint iabs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: builds the index schedule, then iterates with plain integers
    task automatic model(input int cs, input int md, input longint x0, input longint y0,
                         input longint z0, output longint xo, output longint yo,
                         output longint zo, output int s);
        int     sched [$];
        longint x, y, z, xn, yn, zn;
        int     m, sg;
        sched.delete();
        for (int i = (cs == 3) ? 1 : 0; i <= NITR; i++) begin
            sched.push_back(i);
            if (cs == 3 && (i == 4 || i == 13)) sched.push_back(i);
        end
        m = (cs == 1) ? 1 : (cs == 3) ? -1 : 0;
        x = x0; y = y0; z = z0;
        foreach (sched[k]) begin
            if (md == 0) sg = (z >= 0) ? 1 : -1;
            else         sg = (y < 0) ? 1 : -1;
            xn = wrap(x - m * sg * shr(y, sched[k]));
            yn = wrap(y + sg * shr(x, sched[k]));
            zn = wrap(z - sg * e_tab[cs][sched[k]]);
            x = xn; y = yn; z = zn;
        end
        xo = x; yo = y; zo = z;
        s = sched.size();
    endtask

    // Issue one start and follow it to done (or a cycle budget)
    task automatic run_op(input logic [1:0] cs, input logic md, input logic signed [BW-1:0] xi,
                          input logic signed [BW-1:0] yi, input logic signed [BW-1:0] zi,
                          input int restart_at, output int lat, output int busy_n,
                          output int done_w, output logic signed [BW-1:0] xo,
                          output logic signed [BW-1:0] yo, output logic signed [BW-1:0] zo,
                          output logic eo);
        cnt_q.delete();
        lat = -1; busy_n = 0; done_w = 0; xo = '0; yo = '0; zo = '0; eo = 1'b0;
        @(negedge clk_in);
        coordinate_system_in = cs; mode_in = md;
        x_in = xi; y_in = yi; z_in = zi;
        start_in = 1'b1;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk_in);
            if (busy_out) busy_n++;
            if (busy_out && !done_out) cnt_q.push_back(int'(count_out));
            if (j == restart_at) begin
                start_in = 1'b1;
                coordinate_system_in = 2'b00; mode_in = ~md;
                x_in = ~xi; y_in = ~yi; z_in = ~zi;
            end else begin
                start_in = 1'b0;
            end
            if (done_out) begin
                lat = j; done_w = 1;
                xo = x_out; yo = y_out; zo = z_out; eo = error_out;
                @(negedge clk_in);
                if (done_out) done_w++;
                if (busy_out) busy_n++;
                break;
            end
        end
        start_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        n_cmp++;
        if ({count_out, coordinate_system_out, busy_out, done_out, error_out} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0",
                     {count_out, coordinate_system_out, busy_out, done_out, error_out});
        end
        n_cmp++;
        if ({x_out, y_out, z_out} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %0d %0d %0d required 0 0 0", x_out, y_out, z_out);
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        n_cmp++;
        if (busy_out !== 1'b0 || done_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy %b done %b required 0 0", busy_out, done_out);
        end
    endtask

    task automatic test_circ_vectoring();
        int lat, bn, dw, s; logic signed [BW-1:0] xo, yo, zo; logic eo; longint mx, my, mz;
        run_op(2'b01, 1'b1, 16'sd16384, 16'sd0, 16'sd0, 0, lat, bn, dw, xo, yo, zo, eo);
        model(1, 1, 16384, 0, 0, mx, my, mz, s);
        n_cmp++;
        if (lat !== 16) begin n_fail++; $display("FAIL circ_vec_latency: got %0d required 16", lat); end
        n_cmp++;
        if (iabs(longint'(xo) - 26981) > 4 || iabs(longint'(yo)) > 4 || iabs(longint'(zo)) > 4) begin
            n_fail++;
            $display("FAIL circ_vec_value: got %0d %0d %0d required 26981 0 0 (+/-4)", xo, yo, zo);
        end
        n_cmp++;
        if (longint'(xo) != mx || longint'(yo) != my || longint'(zo) != mz) begin
            n_fail++;
            $display("FAIL circ_vec_model: got %0d %0d %0d required %0d %0d %0d", xo, yo, zo, mx, my, mz);
        end
        n_cmp++;
        if (bn !== lat || dw !== 1 || eo !== 1'b0) begin
            n_fail++;
            $display("FAIL circ_vec_status: busy %0d done_w %0d err %b required %0d 1 0", bn, dw, eo, lat);
        end
    endtask

    task automatic test_circ_rotation();
        int lat, bn, dw, s; logic signed [BW-1:0] xo, yo, zo; logic eo; longint mx, my, mz;
        run_op(2'b01, 1'b0, 16'sd9949, 16'sd0, 16'sd12868, 0, lat, bn, dw, xo, yo, zo, eo);
        model(1, 0, 9949, 0, 12868, mx, my, mz, s);
        n_cmp++;
        if (iabs(longint'(xo) - 11585) > 6 || iabs(longint'(yo) - 11585) > 6) begin
            n_fail++;
            $display("FAIL circ_rot_value: got %0d %0d required 11585 11585 (+/-6)", xo, yo);
        end
        n_cmp++;
        if (longint'(xo) != mx || longint'(yo) != my || longint'(zo) != mz || lat != s + 1) begin
            n_fail++;
            $display("FAIL circ_rot_model: got %0d %0d %0d lat %0d required %0d %0d %0d lat %0d",
                     xo, yo, zo, lat, mx, my, mz, s + 1);
        end
    endtask

    task automatic test_linear();
        int lat, bn, dw, s; logic signed [BW-1:0] xo, yo, zo; logic eo; longint mx, my, mz;
        run_op(2'b00, 1'b0, 16'sd8192, 16'sd0, 16'sd8192, 0, lat, bn, dw, xo, yo, zo, eo);
        model(0, 0, 8192, 0, 8192, mx, my, mz, s);
        n_cmp++;
        if (xo !== 16'sd8192 || iabs(longint'(yo) - 4096) > 2) begin
            n_fail++;
            $display("FAIL lin_value: got x %0d y %0d required 8192 4096(+/-2)", xo, yo);
        end
        n_cmp++;
        if (longint'(yo) != my || longint'(zo) != mz || lat != 16) begin
            n_fail++;
            $display("FAIL lin_model: got %0d %0d lat %0d required %0d %0d lat 16", yo, zo, lat, my, mz);
        end
    endtask

    task automatic test_hyp_schedule();
        int lat, bn, dw, s; logic signed [BW-1:0] xo, yo, zo; logic eo; longint mx, my, mz;
        int exp_q [$]; bit seq_ok;
        for (int i = 1; i <= NITR; i++) begin
            exp_q.push_back(i);
            if (i == 4 || i == 13) exp_q.push_back(i);
        end
        run_op(2'b11, 1'b0, 16'sd19784, 16'sd0, 16'sd4096, 0, lat, bn, dw, xo, yo, zo, eo);
        model(3, 0, 19784, 0, 4096, mx, my, mz, s);
        seq_ok = (cnt_q.size() == exp_q.size());
        if (seq_ok) foreach (exp_q[k]) if (cnt_q[k] != exp_q[k]) seq_ok = 1'b0;
        n_cmp++;
        if (!seq_ok) begin
            n_fail++;
            $display("FAIL hyp_sequence: got %p required %p", cnt_q, exp_q);
        end
        n_cmp++;
        if (lat !== 17 || dw !== 1) begin
            n_fail++;
            $display("FAIL hyp_done_timing: got lat %0d width %0d required 17 1", lat, dw);
        end
        n_cmp++;
        if (longint'(xo) != mx || longint'(yo) != my || longint'(zo) != mz) begin
            n_fail++;
            $display("FAIL hyp_model: got %0d %0d %0d required %0d %0d %0d", xo, yo, zo, mx, my, mz);
        end
    endtask

    task automatic test_illegal();
        int lat, bn, dw; logic signed [BW-1:0] xo, yo, zo, px, py, pz; logic eo;
        run_op(2'b00, 1'b0, 16'sd1000, 16'sd300, 16'sd5000, 0, lat, bn, dw, px, py, pz, eo);
        run_op(2'b10, 1'b0, 16'sd7, 16'sd8, 16'sd9, 0, lat, bn, dw, xo, yo, zo, eo);
        n_cmp++;
        if (lat !== 1 || eo !== 1'b1 || bn !== 1 || dw !== 1) begin
            n_fail++;
            $display("FAIL illegal_status: lat %0d err %b busy %0d width %0d required 1 1 1 1", lat, eo, bn, dw);
        end
        n_cmp++;
        if (xo !== px || yo !== py || zo !== pz) begin
            n_fail++;
            $display("FAIL illegal_hold: got %0d %0d %0d required %0d %0d %0d", xo, yo, zo, px, py, pz);
        end
        n_cmp++;
        if (error_out !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_sticky: got %b required 1", error_out);
        end
        run_op(2'b01, 1'b0, 16'sd4000, 16'sd0, 16'sd0, 0, lat, bn, dw, xo, yo, zo, eo);
        n_cmp++;
        if (eo !== 1'b0 || lat !== 16) begin
            n_fail++;
            $display("FAIL illegal_clear: err %b lat %0d required 0 16", eo, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn, dw, s; logic signed [BW-1:0] xo, yo, zo; logic eo; longint mx, my, mz;
        run_op(2'b01, 1'b0, 16'sd12000, -16'sd3000, -16'sd9000, 3, lat, bn, dw, xo, yo, zo, eo);
        model(1, 0, 12000, -3000, -9000, mx, my, mz, s);
        n_cmp++;
        if (lat !== 16 || longint'(xo) != mx || longint'(yo) != my || longint'(zo) != mz) begin
            n_fail++;
            $display("FAIL start_ignored: lat %0d got %0d %0d %0d required 16 %0d %0d %0d",
                     lat, xo, yo, zo, mx, my, mz);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        @(negedge clk_in);
        coordinate_system_in = 2'b01; mode_in = 1'b0;
        x_in = 16'sd9000; y_in = 16'sd1000; z_in = 16'sd2000;
        start_in = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk_in);
            start_in = 1'b0;
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        n_cmp++;
        if ({count_out, coordinate_system_out, busy_out, done_out, error_out} !== 11'd0 ||
            {x_out, y_out, z_out} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_mid_zero: ctrl %b data %0d %0d %0d required all 0",
                     {count_out, coordinate_system_out, busy_out, done_out, error_out}, x_out, y_out, z_out);
        end
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk_in);
            if (done_out || busy_out) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin n_fail++; $display("FAIL reset_mid_abort: got activity required none"); end
        // Reset and start together: reset takes priority
        rst_in = 1'b1; start_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0; start_in = 1'b0;
        @(negedge clk_in);
        n_cmp++;
        if (busy_out !== 1'b0 || done_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wins: busy %b done %b required 0 0", busy_out, done_out);
        end
    endtask

    task automatic test_random();
        int lat, bn, dw, s, cs, md; logic signed [BW-1:0] xo, yo, zo, xi, yi, zi; logic eo;
        longint mx, my, mz; int sel;
        for (int n = 0; n < 12; n++) begin
            sel = int'($urandom_range(0, 2));
            cs  = (sel == 0) ? 0 : (sel == 1) ? 1 : 3;
            md  = int'($urandom_range(0, 1));
            xi = BW'($urandom); yi = BW'($urandom); zi = BW'($urandom);
            run_op(2'(cs), md[0], xi, yi, zi, 0, lat, bn, dw, xo, yo, zo, eo);
            model(cs, md, longint'(xi), longint'(yi), longint'(zi), mx, my, mz, s);
            n_cmp++;
            if (lat != s + 1 || longint'(xo) != mx || longint'(yo) != my || longint'(zo) != mz ||
                eo !== 1'b0 || dw !== 1) begin
                n_fail++;
                $display("FAIL random_%0d cs%0d md%0d: got %0d %0d %0d lat %0d required %0d %0d %0d lat %0d",
                         n, cs, md, xo, yo, zo, lat, mx, my, mz, s + 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            e_tab[0][i] = (i < 31) ? (16384 >> i) : 0;
            e_tab[1][i] = $rtoi($atan($pow(2.0, -i)) * 16384.0 + 0.5);
            e_tab[2][i] = 0;
            e_tab[3][i] = (i == 0) ? 0 : $rtoi($atanh($pow(2.0, -i)) * 16384.0 + 0.5);
        end
        test_reset();
        test_circ_vectoring();
        test_circ_rotation();
        test_linear();
        test_hyp_schedule();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
